hs_npu_layer_sequencer: RTL and testbench
=========================================

HS_NPU_LAYER_SEQUENCER -- requirements
Module: hs_npu_layer_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_LAYERS, default 4, meaning the descriptor table depth (power of 2, at least 2).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, meaning the maximum number of cycles to wait for finished_i per layer.
REQ-003 Port clk, input, 1 bit: the single clock.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port desc_we_i, input, 1 bit: write strobe for the descriptor table.
REQ-006 Port desc_idx_i, input, $clog2(MAX_LAYERS) bits: index of the table entry being written.
REQ-007 Port desc_i, input, layer_desc_t: descriptor data (dims, flags, shift, base and result addresses).
REQ-008 Port num_layers_i, input, $clog2(MAX_LAYERS)+1 bits: number of layers to run, sampled at start.
REQ-009 Port start_i, input, 1 bit: single-cycle pulse that launches a run.
REQ-010 Port abort_i, input, 1 bit: pulse that cancels a run.
REQ-011 Port mo_ready_i, input, 1 bit: memory ordering unit can accept a layer.
REQ-012 Port mo_valid_o, output, 1 bit: the current layer is presented.
REQ-013 Port finished_i, input, 1 bit: pulse marking completion of the current layer.
REQ-014 Port layer_o, output, layer_desc_t: active descriptor, held stable from issue until finished.
REQ-015 Port layer_idx_o, output, $clog2(MAX_LAYERS) bits: index of the active layer.
REQ-016 Port busy_o, output, 1 bit: a run is in progress.
REQ-017 Port irq_o, output, 1 bit: single-cycle pulse at end of run.
REQ-018 Port exit_code_o, output, 2 bits: result of the last run; 0 none, 1 ok, 2 timeout, 3 aborted/invalid.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE and DONE.
REQ-020 In IDLE, start_i with 1 <= num_layers_i <= MAX_LAYERS SHALL latch the count, clear layer_idx, and go to ISSUE on the next cycle.
REQ-021 In IDLE, start_i with num_layers_i == 0 or num_layers_i > MAX_LAYERS SHALL set exit_code=3, pulse irq_o one cycle later, and stay in IDLE.
REQ-022 In ISSUE, mo_valid_o SHALL be 1; a transfer occurs when mo_valid_o && mo_ready_i, which moves to WAIT_DONE and drops valid the next cycle.
REQ-023 mo_valid_o SHALL stay asserted until accepted and SHALL never be deasserted without a transfer, except on abort or reset.
REQ-024 In WAIT_DONE, finished_i SHALL either increment layer_idx and return to ISSUE, or, if it was the last layer, go to DONE.
REQ-025 When finished_i arrives in the same cycle as the transfer in ISSUE, it SHALL be ignored; only finished_i seen in WAIT_DONE counts.
REQ-026 In WAIT_DONE, the timeout counter SHALL reset on entry; reaching TIMEOUT_CYCLES-1 without finished_i SHALL set exit_code=2 and go to DONE.
REQ-027 DONE SHALL last one cycle with irq_o=1, set exit_code=1 if no error occurred, and return to IDLE.
REQ-028 abort_i in ISSUE or WAIT_DONE SHALL go to DONE with exit_code=3; abort_i in IDLE or DONE SHALL be ignored.
REQ-029 start_i while busy_o=1 SHALL be ignored.
REQ-030 abort_i SHALL take priority over finished_i and over timeout in the same cycle.
REQ-031 busy_o SHALL be 1 in ISSUE and WAIT_DONE.
REQ-032 layer_o SHALL be table[layer_idx] registered at entry to ISSUE.
REQ-033 desc_we_i SHALL write the table in any state, but the active layer_o SHALL NOT change until the next ISSUE entry.
REQ-034 exit_code_o SHALL hold its value until the next start_i is accepted, which clears it to 0.
REQ-035 The minimum latency per layer SHALL be ISSUE (1 cycle) + WAIT_DONE (1 cycle or more).

Reset
REQ-036 rst SHALL force state IDLE and mo_valid_o, busy_o, irq_o, layer_idx_o, exit_code_o, the timeout counter and layer_o all to 0.
REQ-037 The descriptor table SHALL NOT be reset.
REQ-038 rst asserted mid-run SHALL cancel the run without an irq.

Structure
REQ-039 layer_desc_t (uword rows/cols for inputs and weights, reuse/save/bias/sum flags, shift amount, activation select, base and result addresses) SHALL live in hs_npu_pkg.
REQ-040 The exit-code enum and the FSM state enum SHALL live in hs_npu_pkg.
REQ-041 The block SHALL be a single module with no sub-modules; the table is an inferred register array.

Verification
REQ-042 num_layers=3 with ready held high and finished 5 cycles after each issue -> three transfers with idx 0,1,2, irq once, exit_code=1.
REQ-043 ready low for 10 cycles during ISSUE -> mo_valid_o held and layer_o stable, transfer on the first ready cycle.
REQ-044 TIMEOUT_CYCLES=16 with finished never asserted -> DONE after 16 WAIT_DONE cycles, exit_code=2, irq pulse.
REQ-045 abort_i in the same cycle as finished_i on layer 1 of 4 -> exit_code=3, no further issue.
REQ-046 start_i with num_layers=0 -> irq, exit_code=3, busy never set; start_i while busy -> ignored.
REQ-047 rst asserted in WAIT_DONE -> all outputs 0 the next cycle, no irq.

Source files
------------

// File: rtl/hs_npu_pkg.sv
// rtl/hs_npu_pkg.sv - shared descriptor, exit-code and state types for the NPU sequencer
package hs_npu_pkg;

  typedef logic [15:0] uword_t;
  typedef logic [31:0] addr_t;

  // One layer of work handed to the memory ordering unit
  typedef struct packed {
    uword_t      in_rows;
    uword_t      in_cols;
    uword_t      w_rows;
    uword_t      w_cols;
    logic        reuse;
    logic        save;
    logic        bias;
    logic        sum;
    logic [4:0]  shift;
    logic [1:0]  act_sel;
    addr_t       base_addr;
    addr_t       result_addr;
  } layer_desc_t;

  typedef enum logic [1:0] {
    EXIT_NONE    = 2'd0,
    EXIT_OK      = 2'd1,
    EXIT_TIMEOUT = 2'd2,
    EXIT_ABORT   = 2'd3
  } exit_code_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    DONE      = 2'd3
  } seq_state_e;

endpackage

// File: rtl/hs_npu_layer_sequencer.sv
// rtl/hs_npu_layer_sequencer.sv - walks a descriptor table, issuing one layer at a time
module hs_npu_layer_sequencer
  import hs_npu_pkg::*;
#(
  parameter int MAX_LAYERS     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  localparam int IDX_W = $clog2(MAX_LAYERS),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_we_i,
  input  logic [IDX_W-1:0]  desc_idx_i,
  input  layer_desc_t       desc_i,
  input  logic [CNT_W-1:0]  num_layers_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              mo_ready_i,
  output logic              mo_valid_o,
  input  logic              finished_i,
  output layer_desc_t       layer_o,
  output logic [IDX_W-1:0]  layer_idx_o,
  output logic              busy_o,
  output logic              irq_o,
  output logic [1:0]        exit_code_o
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  layer_desc_t       table_q [MAX_LAYERS];
  seq_state_e        state_q;
  logic [CNT_W-1:0]  count_q;
  logic [TMR_W-1:0]  timer_q;
  logic              start_ok;
  logic              last_layer;
  logic [IDX_W-1:0]  next_idx;

  // A run length is usable only when it names at least one and at most MAX_LAYERS entries
  always_comb begin
    start_ok   = (num_layers_i != '0) && (num_layers_i <= CNT_W'(MAX_LAYERS));
    last_layer = ({1'b0, layer_idx_o} == (count_q - CNT_W'(1)));
    next_idx   = layer_idx_o + IDX_W'(1);
  end

  // Descriptor table: writable at any time and deliberately left out of reset
  always_ff @(posedge clk) begin
    if (desc_we_i) begin
      table_q[desc_idx_i] <= desc_i;
    end
  end

  // Sequencer FSM; layer_o is captured only on ISSUE entry so table writes cannot disturb it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      timer_q     <= '0;
      mo_valid_o  <= 1'b0;
      busy_o      <= 1'b0;
      irq_o       <= 1'b0;
      layer_idx_o <= '0;
      exit_code_o <= EXIT_NONE;
      layer_o     <= '0;
    end else begin
      irq_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (start_ok) begin
              count_q     <= num_layers_i;
              layer_idx_o <= '0;
              layer_o     <= table_q[0];
              mo_valid_o  <= 1'b1;
              busy_o      <= 1'b1;
              exit_code_o <= EXIT_NONE;
              state_q     <= ISSUE;
            end else begin
              exit_code_o <= EXIT_ABORT;
              irq_o       <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (abort_i) begin
            mo_valid_o  <= 1'b0;
            busy_o      <= 1'b0;
            irq_o       <= 1'b1;
            exit_code_o <= EXIT_ABORT;
            state_q     <= DONE;
          end else if (mo_ready_i) begin
            mo_valid_o <= 1'b0;
            timer_q    <= '0;
            state_q    <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (abort_i) begin
            busy_o      <= 1'b0;
            irq_o       <= 1'b1;
            exit_code_o <= EXIT_ABORT;
            state_q     <= DONE;
          end else if (finished_i) begin
            if (last_layer) begin
              busy_o      <= 1'b0;
              irq_o       <= 1'b1;
              exit_code_o <= EXIT_OK;
              state_q     <= DONE;
            end else begin
              layer_idx_o <= next_idx;
              layer_o     <= table_q[next_idx];
              mo_valid_o  <= 1'b1;
              state_q     <= ISSUE;
            end
          end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            busy_o      <= 1'b0;
            irq_o       <= 1'b1;
            exit_code_o <= EXIT_TIMEOUT;
            state_q     <= DONE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs_npu_layer_sequencer.sv
// tb/tb_hs_npu_layer_sequencer.sv - self-checking bench for hs_npu_layer_sequencer
module tb_hs_npu_layer_sequencer;
  import hs_npu_pkg::*;

  localparam int MAXL  = 4;
  localparam int TOC   = 16;
  localparam int IDX_W = 2;
  localparam int CNT_W = 3;
  localparam int K_FIN   = 0;
  localparam int K_TO    = 1;
  localparam int K_AB    = 2;
  localparam int K_FINAB = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              desc_we_i;
  logic [IDX_W-1:0]  desc_idx_i;
  layer_desc_t       desc_i;
  logic [CNT_W-1:0]  num_layers_i;
  logic              start_i;
  logic              abort_i;
  logic              mo_ready_i;
  logic              mo_valid_o;
  logic              finished_i;
  layer_desc_t       layer_o;
  logic [IDX_W-1:0]  layer_idx_o;
  logic              busy_o;
  logic              irq_o;
  logic [1:0]        exit_code_o;

  always #5 clk = ~clk;

  hs_npu_layer_sequencer #(.MAX_LAYERS(MAXL), .TIMEOUT_CYCLES(TOC)) dut (
    .clk(clk), .rst(rst), .desc_we_i(desc_we_i), .desc_idx_i(desc_idx_i), .desc_i(desc_i),
    .num_layers_i(num_layers_i), .start_i(start_i), .abort_i(abort_i), .mo_ready_i(mo_ready_i),
    .mo_valid_o(mo_valid_o), .finished_i(finished_i), .layer_o(layer_o),
    .layer_idx_o(layer_idx_o), .busy_o(busy_o), .irq_o(irq_o), .exit_code_o(exit_code_o)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  layer_desc_t mtab     [MAXL];
  layer_desc_t exp_desc [MAXL];
  int          plan_kind[MAXL];
  int          plan_d   [MAXL];
  int          xq_idx[$];
  layer_desc_t xq_desc[$];
  int          irq_cnt;
  bit          busy_seen;
  int          last_wait;
  int          issue0_cycles;

  typedef struct {
    int n;
    int rmode;
    bit wr;
    int code;
    int xf;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic layer_desc_t rand_desc();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return layer_desc_t'(r[$bits(layer_desc_t)-1:0]);
  endfunction

  task automatic write_entry(input int i, input layer_desc_t d);
    desc_we_i  = 1'b1;
    desc_idx_i = IDX_W'(i);
    desc_i     = d;
    step();
    desc_we_i  = 1'b0;
    mtab[i]    = d;
  endtask

  function automatic void set_plan(input int k, input int d);
    for (int i = 0; i < MAXL; i++) begin
      plan_kind[i] = k;
      plan_d[i]    = d;
    end
  endfunction

  // Transaction-level outcome of a run: layers handed over, then how the run ends
  function automatic void predict(input int n, output int code, output int xf);
    code = 3;
    xf   = 0;
    if (n < 1 || n > MAXL) return;
    for (int i = 0; i < n; i++) begin
      xf = i + 1;
      if (plan_kind[i] == K_TO) begin
        code = 2;
        return;
      end
      if (plan_kind[i] != K_FIN) begin
        code = 3;
        return;
      end
      if (i == n - 1) code = 1;
    end
  endfunction

  // Passive monitor sampling on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (mo_valid_o && mo_ready_i) begin
        xq_idx.push_back(int'(layer_idx_o));
        xq_desc.push_back(layer_o);
      end
      if (irq_o) irq_cnt++;
      if (busy_o) busy_seen = 1'b1;
    end
  end

  task automatic run(input string tag, input int n, input int rmode, input bit wr_mid,
                     input bit poke, input int exp_code, input int exp_xf);
    int cyc;
    int wait_cnt;
    int vcnt;
    int idx;
    int nchk;
    bit stable_ok;
    bit got_irq;
    cyc = 0; wait_cnt = 0; vcnt = 0; stable_ok = 1'b1; got_irq = 1'b0;
    xq_idx.delete();
    xq_desc.delete();
    irq_cnt = 0; busy_seen = 1'b0; last_wait = 0; issue0_cycles = 0;
    exp_desc[0]  = mtab[0];
    num_layers_i = CNT_W'(n);
    mo_ready_i   = 1'b0;
    start_i      = 1'b1;
    step();
    start_i = 1'b0;
    if (n >= 1 && n <= MAXL) begin
      check({tag, "_exit_clr"}, exit_code_o, 0);
      check({tag, "_busy_on"}, busy_o, 1);
      check({tag, "_valid_on"}, mo_valid_o, 1);
    end
    while (cyc < 400) begin
      if (irq_o) begin
        got_irq = 1'b1;
        break;
      end
      finished_i = 1'b0; abort_i = 1'b0; desc_we_i = 1'b0; start_i = 1'b0;
      idx = int'(layer_idx_o);
      if (busy_o && layer_o !== exp_desc[idx]) stable_ok = 1'b0;
      if (mo_valid_o) begin
        vcnt++;
        if (idx == 0) issue0_cycles = vcnt;
        case (rmode)
          0:       mo_ready_i = 1'b1;
          1:       mo_ready_i = 1'($urandom % 2);
          default: mo_ready_i = (idx != 0) || (vcnt > 10);
        endcase
      end else begin
        vcnt = 0;
        mo_ready_i = 1'($urandom % 2);
      end
      if (busy_o && !mo_valid_o) begin
        wait_cnt++;
        last_wait = wait_cnt;
        if (plan_kind[idx] != K_TO && wait_cnt == plan_d[idx]) begin
          if (plan_kind[idx] != K_AB) begin
            finished_i = 1'b1;
            if (idx + 1 < n) exp_desc[idx + 1] = mtab[idx + 1];
          end
          if (plan_kind[idx] != K_FIN) abort_i = 1'b1;
        end
        if (poke && idx == 0 && wait_cnt == 1) begin
          start_i      = 1'b1;
          num_layers_i = CNT_W'(MAXL);
        end
      end else begin
        wait_cnt = 0;
      end
      if (wr_mid && !finished_i && ($urandom % 3 == 0)) begin
        int w;
        layer_desc_t d;
        w = int'($urandom % MAXL);
        d = rand_desc();
        desc_we_i = 1'b1; desc_idx_i = IDX_W'(w); desc_i = d;
        mtab[w] = d;
      end
      step();
      cyc++;
    end
    check({tag, "_irq_seen"}, got_irq, 1);
    check({tag, "_exit"}, exit_code_o, exp_code);
    finished_i = 1'b0; abort_i = 1'b0; desc_we_i = 1'b0; start_i = 1'b0; mo_ready_i = 1'b0;
    repeat (3) step();
    check({tag, "_irq_cnt"}, irq_cnt, 1);
    check({tag, "_busy_off"}, busy_o, 0);
    check({tag, "_exit_hold"}, exit_code_o, exp_code);
    check({tag, "_busy_seen"}, busy_seen, (exp_xf > 0));
    check({tag, "_nxfer"}, xq_idx.size(), exp_xf);
    nchk = (xq_idx.size() < exp_xf) ? xq_idx.size() : exp_xf;
    for (int i = 0; i < nchk; i++) begin
      check($sformatf("%s_xidx%0d", tag, i), xq_idx[i], i);
      check($sformatf("%s_xdesc%0d", tag, i), xq_desc[i], exp_desc[i]);
    end
    check({tag, "_layer_stable"}, stable_ok, 1);
  endtask

  initial begin
    int code;
    int xf;
    int n;
    int k;
    int cyc;
    rst = 1'b1; desc_we_i = 1'b0; desc_idx_i = '0; desc_i = '0; num_layers_i = '0;
    start_i = 1'b0; abort_i = 1'b0; mo_ready_i = 1'b0; finished_i = 1'b0;
    repeat (3) step();
    check("rst_valid", mo_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_irq", irq_o, 0);
    check("rst_idx", layer_idx_o, 0);
    check("rst_exit", exit_code_o, 0);
    check("rst_layer", layer_o, 0);
    rst = 1'b0;
    for (int i = 0; i < MAXL; i++) write_entry(i, rand_desc());

    vecs[0] = '{0, 0, 1'b0, 3, 0};
    vecs[1] = '{1, 0, 1'b0, 1, 1};
    vecs[2] = '{2, 0, 1'b1, 1, 2};
    vecs[3] = '{4, 0, 1'b0, 1, 4};
    vecs[4] = '{5, 0, 1'b0, 3, 0};
    vecs[5] = '{7, 0, 1'b0, 3, 0};
    vecs[6] = '{3, 1, 1'b1, 1, 3};
    vecs[7] = '{4, 1, 1'b0, 1, 4};
    set_plan(K_FIN, 2);
    for (int i = 0; i < 8; i++) begin
      run($sformatf("vec%0d", i), vecs[i].n, vecs[i].rmode, vecs[i].wr, 1'b0, vecs[i].code, vecs[i].xf);
    end

    set_plan(K_FIN, 5);
    run("three_layers", 3, 0, 1'b0, 1'b0, 1, 3);

    set_plan(K_FIN, 2);
    run("ready_low", 2, 2, 1'b1, 1'b0, 1, 2);
    check("ready_low_hold_cycles", issue0_cycles, 11);

    set_plan(K_TO, 1);
    run("timeout", 1, 0, 1'b0, 1'b0, 2, 1);
    check("timeout_wait_cycles", last_wait, TOC);

    set_plan(K_FIN, 2);
    plan_kind[1] = K_FINAB; plan_d[1] = 3;
    run("abort_fin", 4, 0, 1'b0, 1'b0, 3, 2);

    set_plan(K_FIN, 3);
    run("start_busy", 2, 0, 1'b0, 1'b1, 1, 2);

    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    irq_cnt = 0;
    repeat (3) step();
    check("idle_abort_exit", exit_code_o, 1);
    check("idle_abort_busy", busy_o, 0);
    check("idle_abort_irq", irq_cnt, 0);

    set_plan(K_FIN, 10);
    num_layers_i = CNT_W'(2); mo_ready_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    cyc = 0;
    while (!(busy_o && !mo_valid_o) && cyc < 20) begin
      step();
      cyc++;
    end
    check("rst_mid_reached_wait", (busy_o && !mo_valid_o), 1);
    rst = 1'b1;
    step();
    check("rst_mid_valid", mo_valid_o, 0);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_irq", irq_o, 0);
    check("rst_mid_idx", layer_idx_o, 0);
    check("rst_mid_exit", exit_code_o, 0);
    check("rst_mid_layer", layer_o, 0);
    rst = 1'b0; mo_ready_i = 1'b0; irq_cnt = 0;
    repeat (5) step();
    check("rst_mid_no_irq", irq_cnt, 0);
    check("rst_mid_idle", busy_o, 0);

    for (int r = 0; r < 40; r++) begin
      n = ($urandom % 8 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 4));
      for (int i = 0; i < MAXL; i++) begin
        k = int'($urandom % 10);
        plan_kind[i] = (k < 7) ? K_FIN : (k == 7) ? K_TO : (k == 8) ? K_AB : K_FINAB;
        plan_d[i]    = int'($urandom_range(1, 12));
      end
      predict(n, code, xf);
      run($sformatf("rnd%0d", r), n, 1, 1'($urandom % 2), ($urandom % 4 == 0), code, xf);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
